// File: rtl/systolic_sequencer.sv
// Command-driven controller for the shared systolic array: clear, load B, stream skewed A, drain,
// write C. Optional SYSTOLIC_SEQ_RELU_EN clamps negative result words to zero on write-back.
module systolic_sequencer #(
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned SYSTOLIC_SIZE = 4
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_ni,
  input  logic                                                 start_i,
  input  logic [ADDR_BITS-1:0]                                 a_base_i,
  input  logic [ADDR_BITS-1:0]                                 b_base_i,
  input  logic [ADDR_BITS-1:0]                                 c_base_i,
  output logic                                                 busy_o,
  output logic                                                 done_o,
  output logic                                                 mem_read_valid_o,
  output logic [ADDR_BITS-1:0]                                 mem_read_address_o,
  input  logic                                                 mem_read_ready_i,
  input  logic [DATA_BITS-1:0]                                 mem_read_data_i,
  output logic                                                 mem_write_valid_o,
  output logic [ADDR_BITS-1:0]                                 mem_write_address_o,
  output logic [DATA_BITS-1:0]                                 mem_write_data_o,
  input  logic                                                 mem_write_ready_i,
  output logic                                                 sa_enable_o,
  output logic                                                 sa_clear_acc_o,
  output logic                                                 sa_load_weights_o,
  output logic                                                 sa_compute_enable_o,
  output logic [SYSTOLIC_SIZE*DATA_BITS-1:0]                   sa_a_inputs_o,
  output logic [SYSTOLIC_SIZE*DATA_BITS-1:0]                   sa_b_inputs_o,
  input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE*DATA_BITS-1:0]     sa_results_i,
  input  logic                                                 sa_ready_i
);

  localparam int unsigned N     = SYSTOLIC_SIZE;
  localparam int unsigned NN    = N * N;
  localparam int unsigned CntW  = $clog2(NN) + 1;
  localparam int unsigned LaneW = N * DATA_BITS;
  localparam int unsigned MatW  = NN * DATA_BITS;

  localparam logic [CntW-1:0] LastWord  = CntW'(NN - 1);
  localparam logic [CntW-1:0] LastRow   = CntW'(N - 1);
  localparam logic [CntW-1:0] LastStep  = CntW'(2 * N - 2);
  localparam logic [CntW-1:0] DrainHold = CntW'(N - 2);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StClear  = 4'd1;
  localparam logic [3:0] StReadB  = 4'd2;
  localparam logic [3:0] StWload  = 4'd3;
  localparam logic [3:0] StReadA  = 4'd4;
  localparam logic [3:0] StStream = 4'd5;
  localparam logic [3:0] StDrain  = 4'd6;
  localparam logic [3:0] StWrite  = 4'd7;
  localparam logic [3:0] StDone   = 4'd8;

  logic [3:0]           state_q, state_d;
  logic [CntW-1:0]      idx_q, idx_d, idx_inc;
  logic [ADDR_BITS-1:0] a_base_q, b_base_q, c_base_q, rd_base;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic                 clear_q, clear_d, load_q, load_d, comp_q, comp_d;
  logic [LaneW-1:0]     a_in_q, a_in_d, b_in_q, b_in_d;
  logic [LaneW-1:0]     a_skew_next, b_row_next;
  logic [MatW-1:0]      a_buf_q, b_buf_q, res_q;
  logic                 accept, capture, rd_fire, wr_fire;
  int unsigned          row_sel, t_sel;

  function automatic logic [DATA_BITS-1:0] post_fn(input logic [DATA_BITS-1:0] w);
`ifdef SYSTOLIC_SEQ_RELU_EN
    return w[DATA_BITS-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign idx_inc = idx_q + CntW'(1);
  assign rd_fire = rd_valid_q & mem_read_ready_i;
  assign wr_fire = wr_valid_q & mem_write_ready_i;
  assign rd_base = (state_q == StReadB) ? b_base_q : a_base_q;

  // Lane values for the cycle after this one: next B row in WLOAD, next skew step in STREAM.
  always_comb begin
    a_skew_next = '0;
    b_row_next  = '0;
    row_sel     = (state_q == StWload)  ? 32'(idx_inc) : 32'd0;
    t_sel       = (state_q == StStream) ? 32'(idx_inc) : 32'd0;
    for (int unsigned k = 0; k < N; k++) begin
      if (row_sel < N) begin
        b_row_next[k*DATA_BITS +: DATA_BITS] = b_buf_q[(row_sel*N + k)*DATA_BITS +: DATA_BITS];
      end
      if (t_sel >= k && t_sel - k < N) begin
        a_skew_next[k*DATA_BITS +: DATA_BITS] =
            a_buf_q[(k*N + t_sel - k)*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    clear_d    = 1'b0;
    load_d     = 1'b0;
    comp_d     = 1'b0;
    a_in_d     = '0;
    b_in_d     = '0;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          clear_d = 1'b1;
          idx_d   = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        rd_valid_d = 1'b1;
        rd_addr_d  = b_base_q;
        idx_d      = '0;
        state_d    = StReadB;
      end
      StReadB, StReadA: begin
        if (rd_fire) begin
          if (idx_q == LastWord) begin
            rd_valid_d = 1'b0;
            idx_d      = '0;
            if (state_q == StReadB) begin
              load_d  = 1'b1;
              b_in_d  = b_row_next;
              state_d = StWload;
            end else begin
              comp_d  = 1'b1;
              a_in_d  = a_skew_next;
              state_d = StStream;
            end
          end else begin
            idx_d     = idx_inc;
            rd_addr_d = rd_base + ADDR_BITS'(idx_inc);
          end
        end
      end
      StWload: begin
        if (idx_q == LastRow) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = a_base_q;
          idx_d      = '0;
          state_d    = StReadA;
        end else begin
          idx_d  = idx_inc;
          load_d = 1'b1;
          b_in_d = b_row_next;
        end
      end
      StStream: begin
        if (idx_q == LastStep) begin
          idx_d   = '0;
          state_d = StDrain;
        end else begin
          idx_d  = idx_inc;
          comp_d = 1'b1;
          a_in_d = a_skew_next;
        end
      end
      StDrain: begin
        // Fixed hold for the pipeline to empty, then wait as long as the array needs.
        if (idx_q == DrainHold) begin
          if (sa_ready_i) begin
            capture    = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = c_base_q;
            wr_data_d  = post_fn(sa_results_i[DATA_BITS-1:0]);
            idx_d      = '0;
            state_d    = StWrite;
          end
        end else begin
          idx_d = idx_inc;
        end
      end
      StWrite: begin
        if (wr_fire) begin
          if (idx_q == LastWord) begin
            wr_valid_d = 1'b0;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = StDone;
          end else begin
            idx_d     = idx_inc;
            wr_addr_d = c_base_q + ADDR_BITS'(idx_inc);
            wr_data_d = post_fn(res_q[32'(idx_inc)*DATA_BITS +: DATA_BITS]);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        busy_d     = 1'b0;
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      clear_q    <= 1'b0;
      load_q     <= 1'b0;
      comp_q     <= 1'b0;
      a_in_q     <= '0;
      b_in_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      clear_q    <= clear_d;
      load_q     <= load_d;
      comp_q     <= comp_d;
      a_in_q     <= a_in_d;
      b_in_q     <= b_in_d;
      if (accept) begin
        a_base_q <= a_base_i;
        b_base_q <= b_base_i;
        c_base_q <= c_base_i;
      end
    end
  end

  // Operand and result storage carries no reset; every word is written before it is read.
  always_ff @(posedge clk_i) begin
    if (rd_fire && state_q == StReadB) begin
      b_buf_q[32'(idx_q)*DATA_BITS +: DATA_BITS] <= mem_read_data_i;
    end
    if (rd_fire && state_q == StReadA) begin
      a_buf_q[32'(idx_q)*DATA_BITS +: DATA_BITS] <= mem_read_data_i;
    end
    if (capture) begin
      res_q <= sa_results_i;
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign mem_read_valid_o    = rd_valid_q;
  assign mem_read_address_o  = rd_addr_q;
  assign mem_write_valid_o   = wr_valid_q;
  assign mem_write_address_o = wr_addr_q;
  assign mem_write_data_o    = wr_data_q;
  assign sa_enable_o         = busy_q;
  assign sa_clear_acc_o      = clear_q;
  assign sa_load_weights_o   = load_q;
  assign sa_compute_enable_o = comp_q;
  assign sa_a_inputs_o       = a_in_q;
  assign sa_b_inputs_o       = b_in_q;

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Command-driven controller that owns the core's shared systolic array, which the core currently ties off. On a start pulse it does six things in order: clears the array accumulators, fetches the B (weight) matrix from data memory and loads it into the array, fetches the A matrix, streams A into the array with diagonal skew, drains the array, and writes the N×N result matrix C back to data memory. It occupies one data-memory read channel and one write channel, which the core muxes in while the sequencer is busy.

## Interface
- `DATA_BITS`, default 16: word width (Q1.15).
- `ADDR_BITS`, default 8: data-memory address width.
- `SYSTOLIC_SIZE`, default 4: array dimension N.
- `clk` in 1: system clock; all state on the rising edge.
- `reset` in 1: asynchronous, active-low; forces IDLE and all outputs to their reset values.
- `start` in 1: command strobe; accepted only in IDLE.
- `a_base`, `b_base`, `c_base` in ADDR_BITS: matrix base addresses, sampled when `start` is accepted. Matrices are row-major, element (r,c) at base + r·N + c.
- `busy` out 1: high from acceptance until `done`.
- `done` out 1: one-cycle pulse on completion.
- `mem_read_valid` out 1, `mem_read_address` out ADDR_BITS, `mem_read_ready` in 1, `mem_read_data` in DATA_BITS.
- `mem_write_valid` out 1, `mem_write_address` out ADDR_BITS, `mem_write_data` out DATA_BITS, `mem_write_ready` in 1.
- `sa_enable`, `sa_clear_acc`, `sa_load_weights`, `sa_compute_enable` out 1: array controls.
- `sa_a_inputs`, `sa_b_inputs` out N·DATA_BITS: lane k at bits [k·DATA_BITS +: DATA_BITS].
- `sa_results` in N·N·DATA_BITS: element (r,c) at index r·N+c.
- `sa_ready` in 1: array results valid.

## Operation
- States: IDLE → CLEAR → READ_B → WLOAD → READ_A → STREAM → DRAIN → WRITE → DONE → IDLE.
- IDLE: `start`=1 latches the bases, sets `busy`, and moves to CLEAR. `start` in any other state is ignored.
- CLEAR: `sa_clear_acc`=1 for exactly one cycle.
- READ_B / READ_A:
  - Index i counts 0..N²−1.
  - `mem_read_address` = base + i, truncated to ADDR_BITS, so addresses wrap mod 2^ADDR_BITS.
  - `mem_read_valid` and the address are held until `mem_read_ready`. On valid&&ready, `mem_read_data` is stored to buffer[i].
  - Back-to-back requests are allowed: the next address is presented the following cycle with valid still high.
  - After the last word, valid drops and the state advances.
- WLOAD: N cycles, k=0..N−1. `sa_load_weights`=1 and `sa_b_inputs` lane c = B[k][c].
- STREAM:
  - 2N−1 cycles, t=0..2N−2, with `sa_compute_enable`=1.
  - `sa_a_inputs` lane r = A[r][t−r] when 0 ≤ t−r < N, else 0.
- DRAIN:
  - Holds for N−1 cycles, then waits for `sa_ready`=1.
  - On the cycle `sa_ready` is seen, `sa_results` is captured into a result buffer.
- WRITE:
  - j counts 0..N²−1. Address = c_base + j (wrapping); data = result[j].
  - valid is held until `mem_write_ready`; back-to-back writes are allowed.
- DONE: `done`=1 for one cycle and `busy` drops, both in that same cycle; next state is IDLE.
- `sa_enable`=1 whenever `busy`, else 0.
- Reset mid-operation: the transaction is abandoned, with no further memory requests and no `done`. Buffers need not be cleared.

## Timing
- Reset values:
  - `busy`, `done`, `mem_read_valid`, `mem_write_valid`: 0.
  - `sa_enable`, `sa_clear_acc`, `sa_load_weights`, `sa_compute_enable`: 0.
  - Addresses, `mem_write_data`, `sa_a_inputs`, `sa_b_inputs`: 0.
- All outputs are registered. The first effect of an accepted `start` is `sa_clear_acc`=1 on the next cycle.
- Latency from the `start` cycle to the `done` cycle, with zero-wait memory and `sa_ready` already high when DRAIN ends: 1 + N² + N + N² + (2N−1) + (N−1) + N² + 1 = 3N² + 4N. For N=4 this is 64 cycles.
- Each memory wait cycle and each extra `sa_ready` wait cycle adds exactly one cycle.
- `mem_*_address` and `mem_write_data` must not change while the matching valid is high and ready is low.

## Configuration
- `SYSTOLIC_SEQ_RELU_EN` defined: each result word with its MSB set (negative) is written as 0; non-negative words are written unchanged.
- Not defined: result words are written exactly as captured.
- Latency is identical in both builds.

## Test plan
- Zero-wait run, N=4, a_base=0x00, b_base=0x10, c_base=0x20:
  - Read addresses are 0x10..0x1F, then 0x00..0x0F.
  - Writes go to 0x20..0x2F.
  - `done` pulses exactly 64 cycles after `start`.
- Skew check, A[r][c] = 0x0100·r + c:
  - STREAM t=0: lanes = {0x0000, 0, 0, 0}.
  - t=3: lanes = {0x0003, 0x0102, 0x0201, 0x0300}.
  - t=6: lanes = {0, 0, 0, 0x0303}.
- Backpressure:
  - `mem_read_ready` low for 3 cycles on word 5: address holds at b_base+5 and total latency grows by 3.
  - `mem_write_ready` low for 2 cycles: write address and data hold stable.
- Wrap: c_base=0xF8 with N=4 → writes 0xF8..0xFF, then 0x00..0x07.
- Robustness:
  - `start` pulsed during READ_A is ignored: one `done` only, no base reload.
  - `reset` asserted during WRITE: all outputs are 0 within the same cycle. A new `start` then completes normally.
- RELU build: result word 0x8001 is written as 0x0000 and 0x1234 is written as 0x1234. Without the macro, 0x8001 is written unchanged.
